// File: rtl/a23_trace_packer.sv
// Amber23 trace packer: packs exec/mem/reg events into 72-bit records,
// buffers them in a multi-write FIFO and counts events lost to overflow.
// Optional macro A23_TRACE_OVF_MARKER_EN inserts OVF records after loss.
module a23_trace_packer #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_exec_valid,
    input  logic [31:0]              i_exec_addr,
    input  logic [31:0]              i_exec_op,
    input  logic                     i_mem_valid,
    input  logic                     i_mem_write,
    input  logic [31:0]              i_mem_addr,
    input  logic [31:0]              i_mem_data,
    input  logic                     i_reg_valid,
    input  logic [3:0]               i_reg_num,
    input  logic [31:0]              i_reg_val,
    output logic                     o_trace_valid,
    input  logic                     i_trace_ready,
    output logic [71:0]              o_trace_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [DROP_W-1:0]        o_drop_count,
    input  logic                     i_clr_drops
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [71:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [LW-1:0]     free;
    logic [LW-1:0]     nwr;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;
    logic [1:0]        ndrop;
    logic              pop;
    logic              mark;
    logic [71:0]       cand [4];
    logic [3:0]        cand_v;
    logic [71:0]       slot [4];

`ifdef A23_TRACE_OVF_MARKER_EN
    logic              pend_q, pend_d;
    logic [DROP_W-1:0] acc_q, acc_d, acc_base;
    logic [DROP_W:0]   acc_sum;
    assign mark = pend_q && (free != '0);
`else
    assign mark = 1'b0;
`endif

    // Room is judged from the registered level; a same-cycle pop does not help.
    assign free = LW'(DEPTH) - level_q;
    assign pop  = (level_q != '0) && i_trace_ready;

    // Candidate records in fixed slot order: marker, EXEC, MEM, REG.
    always_comb begin
        cand[0]   = '0;
`ifdef A23_TRACE_OVF_MARKER_EN
        cand[0]   = {3'd7, 5'd0, 32'd0, 32'(acc_q)};
`endif
        cand[1]   = {3'd0, 5'd0, i_exec_addr, i_exec_op};
        cand[2]   = {(i_mem_write ? 3'd2 : 3'd1), 5'd0, i_mem_addr, i_mem_data};
        cand[3]   = {3'd3, 1'b0, i_reg_num, 32'd0, i_reg_val};
        cand_v    = {i_reg_valid, i_mem_valid, i_exec_valid, mark};
    end

    // Compact valid candidates into consecutive slots until space runs out.
    always_comb begin
        nwr   = '0;
        ndrop = '0;
        for (int i = 0; i < 4; i++) slot[i] = '0;
        for (int i = 0; i < 4; i++) begin
            if (cand_v[i]) begin
                if (nwr < free) begin
                    slot[nwr[1:0]] = cand[i];
                    nwr = nwr + LW'(1);
                end else begin
                    ndrop = ndrop + 2'd1;
                end
            end
        end
    end

    // Pointer, level and saturating drop-counter next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + nwr[AW-1:0];
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + nwr - LW'(pop);
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'(ndrop);
        if (i_clr_drops)
            drop_d = '0;
        else if (drop_sum[DROP_W])
            drop_d = '1;
        else
            drop_d = drop_sum[DROP_W-1:0];
    end

`ifdef A23_TRACE_OVF_MARKER_EN
    // Marker accumulator restarts when a marker is emitted this cycle.
    always_comb begin
        acc_base = mark ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + (DROP_W+1)'(ndrop);
        acc_d    = acc_sum[DROP_W] ? '1 : acc_sum[DROP_W-1:0];
        pend_d   = (pend_q && !mark) || (ndrop != '0);
    end

    // Marker state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            pend_q <= pend_d;
            acc_q  <= acc_d;
        end
    end
`endif

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // Record storage: up to four writes per cycle at consecutive slots.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (LW'(i) < nwr) mem_q[wr_ptr_q + AW'(i)] <= slot[i];
        end
    end

    assign o_trace_valid = (level_q != '0);
    assign o_trace_data  = o_trace_valid ? mem_q[rd_ptr_q] : '0;
    assign o_level       = level_q;
    assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_a23_trace_packer.sv
// Self-checking bench for a23_trace_packer against a queue-based model.
// Honours A23_TRACE_OVF_MARKER_EN when defined at compile time.
module tb_a23_trace_packer;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;
    localparam int DMAX   = 65535;

    logic        i_clk;
    logic        i_rst;
    logic        i_exec_valid;
    logic [31:0] i_exec_addr;
    logic [31:0] i_exec_op;
    logic        i_mem_valid;
    logic        i_mem_write;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic        i_reg_valid;
    logic [3:0]  i_reg_num;
    logic [31:0] i_reg_val;
    logic        o_trace_valid;
    logic        i_trace_ready;
    logic [71:0] o_trace_data;
    logic [4:0]  o_level;
    logic [15:0] o_drop_count;
    logic        i_clr_drops;

    a23_trace_packer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_exec_valid(i_exec_valid), .i_exec_addr(i_exec_addr),
        .i_exec_op(i_exec_op),
        .i_mem_valid(i_mem_valid), .i_mem_write(i_mem_write),
        .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
        .i_reg_valid(i_reg_valid), .i_reg_num(i_reg_num),
        .i_reg_val(i_reg_val),
        .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_data(o_trace_data), .o_level(o_level),
        .o_drop_count(o_drop_count), .i_clr_drops(i_clr_drops)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [71:0] mq[$];
    int          mdrops;
    bit          mpend;
    int          macc;
    int          n_checks;
    int          n_fail;

    function automatic logic [71:0] mk(input logic [2:0] t, input logic [4:0] a,
                                       input logic [31:0] ad, input logic [31:0] d);
        return {t, a, ad, d};
    endfunction

    function automatic int sat(input int v);
        return (v > DMAX) ? DMAX : v;
    endfunction

    task automatic idle();
        i_exec_valid  = 1'b0;
        i_mem_valid   = 1'b0;
        i_reg_valid   = 1'b0;
        i_clr_drops   = 1'b0;
    endtask

    // Advance the model by one clock from the current inputs, then the DUT.
    task automatic model_and_clock();
        logic [71:0] add[$];
        int room;
        int nd;
        room = DEPTH - mq.size();
        nd   = 0;
`ifdef A23_TRACE_OVF_MARKER_EN
        if (mpend && room > 0) begin
            add.push_back(mk(3'd7, 5'd0, 32'd0, 32'(macc)));
            room--;
            mpend = 1'b0;
            macc  = 0;
        end
`endif
        if (i_exec_valid) begin
            if (room > 0) begin add.push_back(mk(3'd0, 5'd0, i_exec_addr, i_exec_op)); room--; end
            else nd++;
        end
        if (i_mem_valid) begin
            if (room > 0) begin
                add.push_back(mk(i_mem_write ? 3'd2 : 3'd1, 5'd0, i_mem_addr, i_mem_data));
                room--;
            end else nd++;
        end
        if (i_reg_valid) begin
            if (room > 0) begin add.push_back(mk(3'd3, {1'b0, i_reg_num}, 32'd0, i_reg_val)); room--; end
            else nd++;
        end
        if (mq.size() > 0 && i_trace_ready) void'(mq.pop_front());
        foreach (add[k]) mq.push_back(add[k]);
        mdrops = i_clr_drops ? 0 : sat(mdrops + nd);
`ifdef A23_TRACE_OVF_MARKER_EN
        if (nd > 0) begin
            mpend = 1'b1;
            macc  = sat(macc + nd);
        end
`endif
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        idle();
        i_trace_ready = 1'b0;
        i_rst = 1'b1;
        mq.delete();
        mdrops = 0;
        mpend  = 1'b0;
        macc   = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_trace_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", o_trace_valid);
        end
        n_checks++;
        if (o_level !== 5'd0) begin
            n_fail++; $display("FAIL reset_level: got %0d expected 0", o_level);
        end
        n_checks++;
        if (o_trace_data !== 72'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", o_trace_data);
        end
        n_checks++;
        if (o_drop_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_drops: got %0d expected 0", o_drop_count);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_same_cycle();
        logic [71:0] exp [3];
        exp[0] = {3'd0, 5'd0, 32'h100, 32'hE3A00001};
        exp[1] = {3'd2, 5'd0, 32'h2000, 32'hDEADBEEF};
        exp[2] = {3'd3, 5'd3, 32'h0, 32'h5};
        do_reset();
        i_trace_ready = 1'b1;
        i_exec_valid = 1'b1; i_exec_addr = 32'h100;  i_exec_op = 32'hE3A00001;
        i_mem_valid  = 1'b1; i_mem_write = 1'b1;
        i_mem_addr   = 32'h2000; i_mem_data = 32'hDEADBEEF;
        i_reg_valid  = 1'b1; i_reg_num = 4'd3; i_reg_val = 32'h5;
        model_and_clock();
        idle();
        n_checks++;
        if (o_level !== 5'd3) begin
            n_fail++; $display("FAIL same_level_peak: got %0d expected 3", o_level);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (o_trace_valid !== 1'b1 || o_trace_data !== exp[k]) begin
                n_fail++;
                $display("FAIL same_rec%0d: got %b/%h expected 1/%h", k, o_trace_valid, o_trace_data, exp[k]);
            end
            model_and_clock();
        end
        n_checks++;
        if (o_trace_valid !== 1'b0 || o_level !== 5'd0) begin
            n_fail++; $display("FAIL same_empty: got %b/%0d expected 0/0", o_trace_valid, o_level);
        end
    endtask

    task automatic test_fill_drop();
        do_reset();
        i_trace_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            i_exec_valid = 1'b1;
            i_exec_addr  = 32'(i * 4);
            i_exec_op    = $urandom;
            model_and_clock();
        end
        idle();
        n_checks++;
        if (o_level !== 5'd16) begin
            n_fail++; $display("FAIL fill_level: got %0d expected 16", o_level);
        end
        n_checks++;
        if (o_drop_count !== 16'd2) begin
            n_fail++; $display("FAIL fill_drops: got %0d expected 2", o_drop_count);
        end
        i_trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (o_trace_valid !== 1'b1 || o_trace_data[71:69] !== 3'd0 ||
                o_trace_data[63:32] !== 32'(i * 4) || o_trace_data !== mq[0]) begin
                n_fail++;
                $display("FAIL fill_drain%0d: got %h expected %h", i, o_trace_data, mq[0]);
            end
            model_and_clock();
        end
        n_checks++;
        if (o_level !== 5'd0) begin
            n_fail++; $display("FAIL fill_end_level: got %0d expected 0", o_level);
        end
    endtask

    task automatic test_partial();
        do_reset();
        i_trace_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            i_exec_valid = 1'b1;
            i_exec_addr  = $urandom;
            i_exec_op    = $urandom;
            model_and_clock();
        end
        i_exec_valid = 1'b1; i_exec_addr = 32'hA0; i_exec_op = 32'h11;
        i_mem_valid  = 1'b1; i_mem_write = 1'b0;
        i_mem_addr   = 32'hB0; i_mem_data = 32'h22;
        i_reg_valid  = 1'b1; i_reg_num = 4'd7; i_reg_val = 32'h33;
        i_trace_ready = 1'b1;
        model_and_clock();
        idle();
        i_trace_ready = 1'b0;
        n_checks++;
        if (o_level !== 5'd15) begin
            n_fail++; $display("FAIL partial_level: got %0d expected 15", o_level);
        end
        n_checks++;
        if (o_drop_count !== 16'd1) begin
            n_fail++; $display("FAIL partial_drops: got %0d expected 1", o_drop_count);
        end
        i_trace_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            n_checks++;
            if (o_trace_data !== mq[0]) begin
                n_fail++; $display("FAIL partial_rec%0d: got %h expected %h", k, o_trace_data, mq[0]);
            end
            if (k == 13) begin
                n_checks++;
                if (o_trace_data !== {3'd0, 5'd0, 32'hA0, 32'h11}) begin
                    n_fail++; $display("FAIL partial_exec: got %h expected EXEC A0", o_trace_data);
                end
            end
            if (k == 14) begin
                n_checks++;
                if (o_trace_data !== {3'd1, 5'd0, 32'hB0, 32'h22}) begin
                    n_fail++; $display("FAIL partial_mem: got %h expected MEMRD B0", o_trace_data);
                end
            end
            model_and_clock();
        end
    endtask

    task automatic test_hold_reset();
        logic [71:0] held;
        do_reset();
        i_trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_exec_valid = 1'b1;
            i_exec_addr  = 32'h4000 + 32'(i);
            i_exec_op    = $urandom;
            model_and_clock();
        end
        idle();
        held = mq[0];
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (o_trace_valid !== 1'b1 || o_trace_data !== held) begin
                n_fail++; $display("FAIL hold_stable%0d: got %h expected %h", i, o_trace_data, held);
            end
            model_and_clock();
        end
        #2;
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (o_trace_valid !== 1'b0 || o_level !== 5'd0) begin
            n_fail++; $display("FAIL async_reset: got %b/%0d expected 0/0", o_trace_valid, o_level);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        mq.delete();
        mdrops = 0;
        mpend  = 1'b0;
        macc   = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        i_trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_exec_valid = 1'b1;
            i_exec_addr  = $urandom;
            model_and_clock();
        end
        i_exec_valid = 1'b1;
        i_mem_valid  = 1'b1;
        i_reg_valid  = 1'b1;
        for (int i = 0; i < 21844; i++) model_and_clock();
        i_reg_valid = 1'b0;
        model_and_clock();
        n_checks++;
        if (o_drop_count !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_fffe: got %h expected fffe", o_drop_count);
        end
        i_reg_valid = 1'b1;
        model_and_clock();
        n_checks++;
        if (o_drop_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_ffff: got %h expected ffff", o_drop_count);
        end
        i_clr_drops = 1'b1;
        model_and_clock();
        idle();
        n_checks++;
        if (o_drop_count !== 16'h0) begin
            n_fail++; $display("FAIL clr_priority: got %h expected 0", o_drop_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_checks++;
            if (o_level !== 5'(mq.size()) || o_trace_valid !== (mq.size() != 0) ||
                o_drop_count !== 16'(mdrops) ||
                o_trace_data !== ((mq.size() != 0) ? mq[0] : 72'd0)) begin
                n_fail++;
                $display("FAIL random_c%0d: got lvl=%0d drops=%0d data=%h expected lvl=%0d drops=%0d",
                         c, o_level, o_drop_count, o_trace_data, mq.size(), mdrops);
            end
            i_exec_valid  = 1'($urandom_range(0, 1));
            i_exec_addr   = $urandom;
            i_exec_op     = $urandom;
            i_mem_valid   = 1'($urandom_range(0, 1));
            i_mem_write   = 1'($urandom_range(0, 1));
            i_mem_addr    = $urandom;
            i_mem_data    = $urandom;
            i_reg_valid   = 1'($urandom_range(0, 1));
            i_reg_num     = 4'($urandom_range(0, 15));
            i_reg_val     = $urandom;
            i_trace_ready = ($urandom_range(0, 9) < 4);
            i_clr_drops   = ($urandom_range(0, 31) == 0);
            model_and_clock();
        end
        idle();
    endtask

`ifdef A23_TRACE_OVF_MARKER_EN
    task automatic test_ovf();
        int k;
        do_reset();
        i_trace_ready = 1'b0;
        for (int i = 0; i < 21; i++) begin
            i_exec_valid = 1'b1;
            i_exec_addr  = 32'(i * 4);
            i_exec_op    = $urandom;
            model_and_clock();
        end
        idle();
        i_trace_ready = 1'b1;
        model_and_clock();
        i_trace_ready = 1'b0;
        i_exec_valid = 1'b1; i_exec_addr = 32'hABC; i_exec_op = 32'h1;
        model_and_clock();
        idle();
        n_checks++;
        if (o_level !== 5'd16 || o_drop_count !== 16'd6) begin
            n_fail++; $display("FAIL ovf_state: got %0d/%0d expected 16/6", o_level, o_drop_count);
        end
        i_trace_ready = 1'b1;
        k = 0;
        while (mq.size() > 0 && k < 40) begin
            n_checks++;
            if (o_trace_data !== mq[0]) begin
                n_fail++; $display("FAIL ovf_rec%0d: got %h expected %h", k, o_trace_data, mq[0]);
            end
            if (k == 15) begin
                n_checks++;
                if (o_trace_data !== {3'd7, 5'd0, 32'd0, 32'd5}) begin
                    n_fail++; $display("FAIL ovf_marker5: got %h expected OVF 5", o_trace_data);
                end
            end
            if (k == 16) begin
                n_checks++;
                if (o_trace_data !== {3'd7, 5'd0, 32'd0, 32'd1}) begin
                    n_fail++; $display("FAIL ovf_marker1: got %h expected OVF 1", o_trace_data);
                end
            end
            model_and_clock();
            k++;
        end
        n_checks++;
        if (k != 17) begin
            n_fail++; $display("FAIL ovf_count: got %0d expected 17", k);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_exec_addr = '0; i_exec_op = '0; i_mem_write = 1'b0;
        i_mem_addr  = '0; i_mem_data = '0; i_reg_num = '0; i_reg_val = '0;
        test_reset();
        test_same_cycle();
        test_fill_drop();
        test_partial();
        test_hold_reset();
        test_saturation();
        test_random();
`ifdef A23_TRACE_OVF_MARKER_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
